// File: rtl/riscv_lsu.sv
// riscv_lsu -- single-outstanding load/store unit between a RISC-V core and a
// word-wide data memory.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   core_req_i, core_we_i   core access request and store/load select
//   core_size_i             0 LB, 1 LH, 2 LW/SW, 4 LBU, 5 LHU
//   core_addr_i, core_wd_i  byte address and right-aligned store data
//   core_rd_o               extended load result (valid in DONE, held otherwise)
//   core_stall_o            core must hold PC and suppress write-back
//   core_err_o              one-cycle pulse in DONE for misaligned/illegal access
//   mem_req_o, mem_we_o     memory request strobe and write enable
//   mem_be_o, mem_addr_o    byte-lane enables and word-aligned address
//   mem_wd_o                lane-replicated store data
//   mem_rd_i, mem_ready_i   memory read word and completion (sampled in BUSY)
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic                err_q;
  logic                we_q;
  logic [2:0]          size_q;
  logic [1:0]          lo_q;
  logic [DATA_W-1:0]   wd_q;
  logic                req_legal;

  // Unsigned stores (size 4/5) have no meaning and are rejected with the
  // reserved sizes and misaligned halves/words.
  function automatic logic is_legal(input logic we, input logic [2:0] size,
                                    input logic [1:0] lo);
    case (size)
      3'd0:    is_legal = 1'b1;
      3'd4:    is_legal = !we;
      3'd1:    is_legal = !lo[0];
      3'd5:    is_legal = !we && !lo[0];
      3'd2:    is_legal = (lo == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // size[1:0] separates byte / half / word for both signed and unsigned codes.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lo);
    case (size[1:0])
      2'd0:    lane_be = 4'b0001 << lo;
      2'd1:    lane_be = 4'b0011 << {lo[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_rep(input logic [2:0] size,
                                                 input logic [DATA_W-1:0] wd);
    case (size[1:0])
      2'd0:    lane_rep = {4{wd[7:0]}};
      2'd1:    lane_rep = {2{wd[15:0]}};
      default: lane_rep = wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [2:0] size, input logic [1:0] lo,
                                                 input logic [DATA_W-1:0] word);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      3'd0:    r = b;                       // sign-extends: both sides signed
      3'd1:    r = h;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = word;
    endcase
    load_fmt = r;
  endfunction

  assign req_legal = core_req_i && is_legal(core_we_i, core_size_i, core_addr_i[1:0]);

  // Request and stall are combinational so the memory sees the access in the
  // same cycle the core issues it; reset masks them immediately.
  assign mem_req_o    = !rst_i && (state_q == IDLE) && req_legal;
  assign core_stall_o = !rst_i && (((state_q == IDLE) && core_req_i) || (state_q == BUSY));
  assign mem_we_o     = mem_req_o && core_we_i;
  assign mem_be_o     = mem_req_o ? lane_be(core_size_i, core_addr_i[1:0]) : 4'b0000;
  assign mem_addr_o   = {core_addr_i[31:2], 2'b00};
  assign mem_wd_o     = (state_q == IDLE) ? lane_rep(core_size_i, core_wd_i)
                                          : lane_rep(size_q, wd_q);
  assign core_err_o   = err_q;

  // Request capture: attributes needed after the request cycle
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && core_req_i) begin
      we_q   <= core_we_i;
      size_q <= core_size_i;
      lo_q   <= core_addr_i[1:0];
      wd_q   <= core_wd_i;
    end
  end

  // Control FSM and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      core_rd_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (core_req_i) begin
            if (req_legal) begin
              state_q <= BUSY;
            end else begin
              state_q   <= DONE;
              err_q     <= 1'b1;
              core_rd_o <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            core_rd_o <= we_q ? '0 : load_fmt(size_q, lo_q, mem_rd_i);
            state_q   <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu -- directed bench for riscv_lsu with a byte-lane memory model
// and a scoreboard of expected completions.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wd = 32'd0;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;

  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) if (mem_req) n_pulse <= n_pulse + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one access at the current point (just after a falling edge),
  // serves it from the memory model after 'rdy' BUSY cycles and checks the
  // completion against the scoreboard.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input int rdy,
                        input logic exp_req, input logic [3:0] exp_be,
                        input logic chk_wd, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
    exp_t        e;
    exp_t        got;
    int          stall_cnt;
    int          busy;
    int          pulses0;
    logic [31:0] lat;
    logic [31:0] w;
    e.rd = exp_rd; e.err = exp_err; e.stall = exp_stall; e.tag = tag;
    sb.push_back(e);
    pulses0   = n_pulse;
    core_req  = 1'b1;
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
    #1;
    check({tag, "_mem_req"}, mem_req, exp_req);
    check({tag, "_stall_req"}, core_stall, 1'b1);
    check({tag, "_mem_be"}, mem_be, exp_be);
    check({tag, "_mem_we"}, mem_we, exp_req & we);
    check({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
    if (chk_wd) check({tag, "_mem_wd"}, mem_wd, exp_wd);
    lat = mem_addr;
    if (mem_req && mem_we) begin
      w = mem.exists(lat) ? mem[lat] : 32'h0;
      for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wd[8*i +: 8];
      mem[lat] = w;
    end
    stall_cnt = 1;
    busy = 0;
    @(negedge clk);
    while (core_stall && busy < 50) begin
      busy++;
      stall_cnt++;
      if (busy == 1) check({tag, "_mem_req_busy"}, mem_req, 1'b0);
      mem_ready = (busy == rdy);
      mem_rd    = mem.exists(lat) ? mem[lat] : 32'h0;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    check({tag, "_done_stall"}, core_stall, 1'b0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({got.tag, "_rd"}, core_rd, got.rd);
      check({got.tag, "_err"}, core_err, got.err);
      check({got.tag, "_stall_cycles"}, stall_cnt, got.stall);
      check({got.tag, "_req_pulses"}, n_pulse - pulses0, exp_req ? 1 : 0);
      core_req = 1'b0;
      @(negedge clk);
      #1;
      check({got.tag, "_idle_err"}, core_err, 1'b0);
      check({got.tag, "_idle_stall"}, core_stall, 1'b0);
      check({got.tag, "_rd_hold"}, core_rd, got.rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rd", core_rd, 32'h0);
    check("rst_stall", core_stall, 1'b0);
    check("rst_err", core_err, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_be", mem_be, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_stall", core_stall, 1'b0);
    check("idle_mem_req", mem_req, 1'b0);

    mem[32'h100] = 32'h80FF_1234;
    mem[32'h200] = 32'hBEEF_0000;
    mem[32'h0]   = 32'hCAFE_F00D;

    //     tag      we    sz    addr          wd            rdy req be     chkwd wd            rd            err   stall
    access("lb",    1'b0, 3'd0, 32'h103,      32'h0,        1,  1'b1, 4'h8, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0, 2);
    access("lhu",   1'b0, 3'd5, 32'h202,      32'h0,        3,  1'b1, 4'hC, 1'b0, 32'h0,        32'h0000_BEEF, 1'b0, 4);
    access("sb",    1'b1, 3'd0, 32'h301,      32'h1234_56AB, 1, 1'b1, 4'h2, 1'b1, 32'hABAB_ABAB, 32'h0,        1'b0, 2);
    access("lw_mis",1'b0, 3'd2, 32'h402,      32'h0,        1,  1'b0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1);
    access("lbu",   1'b0, 3'd4, 32'h103,      32'h0,        1,  1'b1, 4'h8, 1'b0, 32'h0,        32'h0000_0080, 1'b0, 2);
    access("lh_mis",1'b0, 3'd1, 32'h201,      32'h0,        1,  1'b0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1);
    access("sz3",   1'b0, 3'd3, 32'h0,        32'h0,        1,  1'b0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1);
    access("sbu",   1'b1, 3'd4, 32'h0,        32'h55,       1,  1'b0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1);
    access("lh",    1'b0, 3'd1, 32'h202,      32'h0,        2,  1'b1, 4'hC, 1'b0, 32'h0,        32'hFFFF_BEEF, 1'b0, 3);

    // Reset in the middle of a BUSY wait.
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h0; core_wd = 32'h0;
    @(negedge clk);
    #1;
    check("rstbusy_stall_pre", core_stall, 1'b1);
    rst = 1'b1;
    #1;
    check("rstbusy_rd", core_rd, 32'h0);
    check("rstbusy_stall", core_stall, 1'b0);
    check("rstbusy_err", core_err, 1'b0);
    check("rstbusy_mem_req", mem_req, 1'b0);
    check("rstbusy_mem_we", mem_we, 1'b0);
    check("rstbusy_mem_be", mem_be, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    access("lw0",   1'b0, 3'd2, 32'h0,        32'h0,        1,  1'b1, 4'hF, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0, 2);

    access("sw10",  1'b1, 3'd2, 32'h10,       32'hDEAD_BEEF, 1, 1'b1, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0,        1'b0, 2);
    access("lw10",  1'b0, 3'd2, 32'h10,       32'h0,        1,  1'b1, 4'hF, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 2);
    access("sh12",  1'b1, 3'd1, 32'h12,       32'h0000_A5C3, 2, 1'b1, 4'hC, 1'b1, 32'hA5C3_A5C3, 32'h0,        1'b0, 3);
    access("lw10b", 1'b0, 3'd2, 32'h10,       32'h0,        1,  1'b1, 4'hF, 1'b0, 32'h0,        32'hA5C3_BEEF, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have port: clk_i  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: core_req_i  input  1  core requests a data access; held stable while core_stall_o=1.
REQ-004 SHALL have port: core_we_i  input  1  1=store, 0=load.
REQ-005 SHALL have port: core_size_i  input  3  access size:
  - 0 = byte signed
  - 1 = half signed
  - 2 = word
  - 4 = byte unsigned
  - 5 = half unsigned
REQ-006 SHALL have port: core_addr_i  input  32  byte address.
REQ-007 SHALL have port: core_wd_i  input  32  store data, right-aligned.
REQ-008 SHALL have port: core_rd_o  output  32  load result, extended.
REQ-009 SHALL have port: core_stall_o  output  1  core must hold PC and suppress register write-back.
REQ-010 SHALL have port: core_err_o  output  1  one-cycle pulse, misaligned or illegal access.
REQ-011 SHALL have port: mem_req_o  output  1  memory request strobe.
REQ-012 SHALL have port: mem_we_o  output  1  memory write enable.
REQ-013 SHALL have port: mem_be_o  output  4  byte-lane enables.
REQ-014 SHALL have port: mem_addr_o  output  32  word-aligned address, {core_addr_i[31:2],2'b00}.
REQ-015 SHALL have port: mem_wd_o  output  32  lane-replicated store data.
REQ-016 SHALL have port: mem_rd_i  input  32  memory read word.
REQ-017 SHALL have port: mem_ready_i  input  1  memory completion, sampled only in BUSY.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 In IDLE with core_req_i=0, the block SHALL hold core_stall_o=0 and mem_req_o=0.
REQ-020 In IDLE with core_req_i=1 and a legal, aligned access, the block SHALL:
  - assert mem_req_o and core_stall_o combinationally;
  - latch we, size, addr[1:0] and wd;
  - go to BUSY.
REQ-021 In BUSY, the block SHALL:
  - hold mem_req_o=0 and core_stall_o=1;
  - on mem_ready_i=1, register the formatted load data into core_rd_o and go to DONE;
  - otherwise remain in BUSY indefinitely.
REQ-022 In DONE, the block SHALL hold core_stall_o=0 and core_rd_o valid, then go to IDLE unconditionally.
REQ-023 Minimum stall SHALL be 2 cycles (request cycle plus ready cycle), with the result consumed in cycle 3.
REQ-024 Misaligned or illegal accesses SHALL cover:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 3, 6 or 7;
  - store with size 4 or 5.
REQ-025 On a misaligned or illegal access, the block SHALL:
  - keep mem_req_o=0;
  - go directly to DONE with core_rd_o=0;
  - pulse core_err_o in DONE;
  - stall only the request cycle.
REQ-026 mem_be_o SHALL be:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<{addr[1],1'b0};
  - word: 4'b1111;
  - 0 when mem_req_o=0.
REQ-027 mem_wd_o SHALL be:
  - byte: {4{wd[7:0]}};
  - half: {2{wd[15:0]}};
  - word: wd.
REQ-028 Load lane select SHALL be:
  - byte: mem_rd_i[8*addr[1:0]+:8];
  - half: mem_rd_i[16*addr[1]+:16];
  - sizes 0 and 1 sign-extended, sizes 4 and 5 zero-extended.
REQ-029 Stores SHALL complete identically via mem_ready_i, with core_rd_o=0 in DONE.
REQ-030 core_rd_o SHALL retain its last value outside DONE.
REQ-031 mem_we_o SHALL equal core_we_i while mem_req_o=1, and 0 otherwise.

Reset
REQ-032 rst_i=1 SHALL immediately force, including mid-transaction in BUSY:
  - state to IDLE;
  - core_rd_o=0, core_stall_o=0, core_err_o=0;
  - mem_req_o=0, mem_we_o=0, mem_be_o=0.
REQ-033 After rst_i deasserts, the first rising edge SHALL accept a new request normally.

Verification
REQ-034 LB at addr 0x103, memory word 0x80FF_1234, ready after 1 cycle -> mem_be_o=0x8, mem_addr_o=0x100, core_rd_o=0xFFFF_FF80, stall 2 cycles.
REQ-035 LHU at 0x202, word 0xBEEF_0000, ready after 3 BUSY cycles -> core_rd_o=0x0000_BEEF, stall 4 cycles.
REQ-036 SB of wd 0x1234_56AB at 0x301 -> mem_we_o=1, mem_be_o=0x2, mem_wd_o=0xABAB_ABAB.
REQ-037 LW at 0x402 -> no mem_req_o, core_err_o pulse, core_rd_o=0, stall 1 cycle.
REQ-038 rst_i asserted in BUSY with mem_ready_i=0 -> all outputs 0 immediately; an LW at 0x0 after release completes normally.
REQ-039 Back-to-back SW 0x10 then LW 0x10 -> load returns the stored word, and each access shows a distinct mem_req_o pulse.
